// File: rtl/otbn_mont_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otbn_mont_pkg
// Purpose  : Shared types and sizing helpers for the sequential Montgomery
//            multiplier (otbn_mont_mul_seq / otbn_mont_step).
//            - mont_state_e : FSM state encoding (IDLE, ITER, FINAL, DONE)
//            - mont_latency : accept-to-out_valid latency in cycles
//            - mont_cnt_width : width of the ITER bit counter
// Config   : OTBN_MONT_MUL_RADIX4_EN halves the ITER phase (two steps/cycle).
// Revision : 1.0  initial release
// ============================================================================
package otbn_mont_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } mont_state_e;

    localparam int unsigned c_DATA_WIDTH = 32;

    // Accept edge is cycle 0; ITER phase, then one FINAL cycle, then DONE.
    function automatic int unsigned mont_latency(input int unsigned w);
`ifdef OTBN_MONT_MUL_RADIX4_EN
        return w / 2 + 2;
`else
        return w + 2;
`endif
    endfunction

    function automatic int unsigned mont_cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

    localparam int unsigned c_LATENCY   = mont_latency(c_DATA_WIDTH);
    localparam int unsigned c_CNT_WIDTH = mont_cnt_width(c_DATA_WIDTH);

endpackage : otbn_mont_pkg
`default_nettype wire

// File: rtl/otbn_mont_step.sv
`default_nettype none
// ============================================================================
// Module   : otbn_mont_step
// Purpose  : One combinational radix-2 Montgomery step:
//              t = acc + (bit ? b : 0); if t odd, t += q; acc_next = t >> 1
// Ports    : i_acc      [W:0]   running accumulator (< 2q)
//            i_bit              current multiplicand bit a[cnt]
//            i_b        [W-1:0] multiplier
//            i_q        [W-1:0] odd modulus
//            o_acc_next [W:0]   next accumulator (< 2q)
// Revision : 1.0  initial release
// ============================================================================
module otbn_mont_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   i_acc,
    input  logic                  i_bit,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [DATA_WIDTH-1:0] i_q,
    output logic [DATA_WIDTH:0]   o_acc_next
);

    // t needs W+2 bits: acc < 2q and b < q give t < 3q before the q fix-up
    // and < 4q after, while q < 2^(W-1).
    logic [DATA_WIDTH+1:0] w_sum;
    logic [DATA_WIDTH+1:0] w_sum_q;
    logic                  w_unused_lsb;

    assign w_sum   = {1'b0, i_acc} + (i_bit ? {2'b00, i_b} : '0);
    assign w_sum_q = w_sum + (w_sum[0] ? {2'b00, i_q} : '0);

    // With an odd q the fixed-up sum is always even, so the LSB is dropped.
    assign o_acc_next   = w_sum_q[DATA_WIDTH+1:1];
    assign w_unused_lsb = w_sum_q[0];

endmodule : otbn_mont_step
`default_nettype wire

// File: rtl/otbn_mont_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : otbn_mont_mul_seq
// Purpose  : Sequential radix-2 Montgomery multiplier,
//            res = a * b * 2^(-W) mod q, valid/ready on both sides.
// Ports    : clk_i, rst_i (sync, active-high)
//            in_valid_i / in_ready_o  : operand triple handshake
//            a_i, b_i, q_i [W-1:0]    : operands (a, b < q; q odd, < 2^(W-1))
//            out_valid_o / out_ready_i: result handshake
//            res_o [W-1:0]            : registered result, < q
//            busy_o                   : high whenever not IDLE
// Config   : OTBN_MONT_MUL_RADIX4_EN - two chained steps per ITER cycle,
//            latency W/2+2 instead of W+2; results identical.
// Revision : 1.0  initial release
// ============================================================================
module otbn_mont_mul_seq
    import otbn_mont_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  busy_o
);

    localparam int unsigned c_CW = mont_cnt_width(DATA_WIDTH);
`ifdef OTBN_MONT_MUL_RADIX4_EN
    localparam int unsigned c_STEP = 2;
`else
    localparam int unsigned c_STEP = 1;
`endif
    localparam logic [c_CW-1:0] c_CNT_INC  = c_CW'(c_STEP);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DATA_WIDTH - c_STEP);

    mont_state_e           r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_q;
    logic [DATA_WIDTH:0]   r_acc;
    logic [c_CW-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0] r_res;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;

    logic [DATA_WIDTH:0]   w_acc_s0;
    logic [DATA_WIDTH:0]   w_acc_step;
    logic                  w_acc_ge_q;
    logic [DATA_WIDTH-1:0] w_res;

    otbn_mont_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step0 (
        .i_acc      (r_acc),
        .i_bit      (r_a[r_cnt]),
        .i_b        (r_b),
        .i_q        (r_q),
        .o_acc_next (w_acc_s0)
    );

`ifdef OTBN_MONT_MUL_RADIX4_EN
    logic [c_CW-1:0]     w_cnt_p1;
    logic [DATA_WIDTH:0] w_acc_s1;

    // cnt is always even here, so cnt+1 never wraps within a transaction.
    assign w_cnt_p1 = r_cnt + 1'b1;

    otbn_mont_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step1 (
        .i_acc      (w_acc_s0),
        .i_bit      (r_a[w_cnt_p1]),
        .i_b        (r_b),
        .i_q        (r_q),
        .o_acc_next (w_acc_s1)
    );

    assign w_acc_step = w_acc_s1;
`else
    assign w_acc_step = w_acc_s0;
`endif

    // acc < 2q < 2^W, so the difference fits in W bits; the W-bit subtract
    // yields the exact value whenever acc >= q.
    assign w_acc_ge_q = (r_acc >= {1'b0, r_q});
    assign w_res      = w_acc_ge_q ? (r_acc[DATA_WIDTH-1:0] - r_q)
                                   : r_acc[DATA_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_res       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_a        <= a_i;
                        r_b        <= b_i;
                        r_q        <= q_i;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_state    <= ITER;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ITER: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + c_CNT_INC;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= FINAL;
                    end
                end
                FINAL: begin
                    r_res       <= w_res;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign busy_o      = r_busy;
    assign res_o       = r_res;

endmodule : otbn_mont_mul_seq
`default_nettype wire

// File: tb/tb_otbn_mont_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_otbn_mont_mul_seq
// Purpose  : Self-checking bench for otbn_mont_mul_seq (W=32). Expected
//            results come from a reference model (a*b mod q, then W modular
//            halvings) queued at each accept and popped at each out_valid.
// Config   : OTBN_MONT_MUL_RADIX4_EN selects the shorter expected latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_otbn_mont_mul_seq;

    localparam int W = 32;
`ifdef OTBN_MONT_MUL_RADIX4_EN
    localparam int LAT = W / 2 + 2;
`else
    localparam int LAT = W + 2;
`endif
    localparam int SPACING = LAT + 1;
    localparam logic [W-1:0] Q0 = 32'd3329;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b, q;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [W-1:0] sb[$];

    otbn_mont_mul_seq #(
        .DATA_WIDTH (W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .q_i         (q),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a*b*2^-W mod q: reduce the product, then halve modulo q W times.
    function automatic logic [W-1:0] model(input longint unsigned ma,
                                           input longint unsigned mb,
                                           input longint unsigned mq);
        longint unsigned x;
        x = (ma * mb) % mq;
        for (int i = 0; i < W; i++) begin
            x = x[0] ? ((x + mq) >> 1) : (x >> 1);
        end
        return x[W-1:0];
    endfunction

    task automatic check(input string tag, input longint unsigned obs,
                         input longint unsigned exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait for in_ready, drive one triple, return on the negedge after the
    // accept edge (first cycle of ITER).
    task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [W-1:0] tq);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", in_ready, 1);
        a = ta; b = tb; q = tq; in_valid = 1'b1;
        sb.push_back(model(ta, tb, tq));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called on the first negedge after accept; stops on the out_valid negedge.
    task automatic wait_result(input bit chk_lat, input string tag);
        int k;
        logic [W-1:0] exp;
        k = 1;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (chk_lat) check({tag, "_latency"}, k, LAT);
        exp = (sb.size() > 0) ? sb.pop_front() : '1;
        check({tag, "_res"}, res, exp);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, in_ready, 1);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_out_valid"}, out_valid, 0);
    endtask

    initial begin
        int prev_cyc;
        int k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; q = Q0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_res", res, 0);
        rst = 1'b0;

        // Directed products with hand-known results (R mod q = 1353).
        accept(32'd1353, 32'd17, Q0);
        check("iter_busy", busy, 1);
        check("iter_in_ready", in_ready, 0);
        wait_result(1'b1, "r17");
        check("r17_const", res, 17);
        handshake("r17");

        accept(32'd1353, 32'd1353, Q0); wait_result(1'b1, "r1353");
        check("r1353_const", res, 1353); handshake("r1353");
        accept(32'd3328, 32'd1353, Q0); wait_result(1'b1, "r3328");
        check("r3328_const", res, 3328); handshake("r3328");
        accept(32'd0, 32'd2000, Q0); wait_result(1'b1, "r0");
        check("r0_const", res, 0); handshake("r0");

        // Back-pressure: hold DONE 10 cycles with a competing triple offered.
        accept(32'd1353, 32'd1353, Q0);
        wait_result(1'b1, "hold");
        in_valid = 1'b1; a = 32'd7; b = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_res", res, 1353);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        handshake("hold");
        @(negedge clk);
        check("hold_second_ignored_busy", busy, 0);

        // Reset in the middle of ITER discards the operation.
        accept(32'd1353, 32'd17, Q0);
        repeat (9) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_res", res, 0);
        accept(32'd1353, 32'd5, Q0); wait_result(1'b1, "post_rst");
        check("post_rst_const", res, 5); handshake("post_rst");

        // Upper modulus range: acc < 2q invariant.
        accept(32'd8380416, 32'd8380416, 32'd8380417);
        wait_result(1'b1, "bigq");
        check("bigq_lt_q", (res < 32'd8380417), 1);
        handshake("bigq");

        // Back-to-back random run, in_valid and out_ready held high.
        out_ready = 1'b1;
        prev_cyc  = 0;
        for (int i = 0; i < 1000; i++) begin
            k = 0;
            @(negedge clk);
            while (!in_ready && k < 200) begin
                @(negedge clk);
                k++;
            end
            a = W'($urandom_range(3328));
            b = W'($urandom_range(3328));
            q = Q0;
            in_valid = 1'b1;
            sb.push_back(model(a, b, q));
            @(posedge clk);
            @(negedge clk);
            if (i > 0) check("b2b_spacing", cyc - prev_cyc, SPACING);
            prev_cyc = cyc;
            wait_result(1'b0, "b2b");
        end
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("end_idle_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_otbn_mont_mul_seq
`default_nettype wire

// File: doc/otbn_mont_mul_seq.md
# otbn_mont_mul_seq

Sequential radix-2 Montgomery modular multiplier, directly upstream of the modular adder in the PQ butterfly datapath. It computes res = a·b·2^(-DATA_WIDTH) mod q; the result is the twiddle product consumed by the adder/subtractor stage. It accepts one operand triple per transaction over a valid/ready handshake and holds its result until the consumer accepts it.

## Interface
- DATA_WIDTH, 32: operand/modulus width W. Must be even.
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operand triple valid.
- in_ready_o  out  1  block can accept a triple.
- a_i  in  W  multiplicand; precondition a_i < q_i.
- b_i  in  W  multiplier; precondition b_i < q_i.
- q_i  in  W  modulus; precondition odd, 3 ≤ q_i < 2^(W-1).
- out_valid_o  out  1  res_o holds a finished result.
- out_ready_i  in  1  consumer accepts res_o.
- res_o  out  W  Montgomery product, always < q.
- busy_o  out  1  high in any state except IDLE.

## Operation
- States: IDLE, ITER, FINAL, DONE.
- IDLE: in_ready_o=1. On in_valid_i: latch a, b, q into internal registers; acc←0; cnt←0; go to ITER. Inputs are ignored after the accept edge.
- ITER: one step per cycle, using bit a[cnt]:
  - t = acc + (a[cnt] ? b : 0);
  - if t is odd, t = t + q;
  - acc ← t >> 1.
  - cnt increments each cycle. On the step with cnt = W-1, go to FINAL.
- Width rule: acc is W+1 bits and t is W+2 bits. The invariant acc < 2q holds after every step, so no bit is lost.
- FINAL: res ← (acc ≥ q) ? acc − q : acc, truncated to W bits; go to DONE.
- DONE: out_valid_o=1 and res_o is stable. On out_ready_i, go to IDLE. With no out_ready_i, hold indefinitely.
- No overlap: in_ready_o=0 in ITER, FINAL and DONE. A new triple can be accepted only in IDLE, i.e. earliest the cycle after the DONE handshake.
- Reset behaviour:
  - rst_i in any state returns to IDLE on that edge and discards any in-flight operation.
  - Reset values: out_valid_o=0, in_ready_o=1, busy_o=0, res_o=0.
  - rst_i has priority over a same-cycle in_valid_i or out_ready_i.
- Precondition violations (even q, a ≥ q, b ≥ q): the result is undefined, but the FSM timing is unchanged and the FSM never hangs.

## Timing
- Accept edge is cycle 0.
- Radix-2 build: ITER occupies cycles 1..W, FINAL is cycle W+1, out_valid_o rises at cycle W+2. Latency is W+2 cycles (34 for W=32).
- Throughput: one result per W+3 cycles when out_ready_i is held high.
- in_ready_o, out_valid_o and busy_o are decoded from registered state only; there is no combinational path from inputs to outputs.
- res_o is registered and changes only on the FINAL→DONE edge or on reset.

## Configuration
- OTBN_MONT_MUL_RADIX4_EN:
  - Defined: ITER performs two chained radix-2 steps per cycle, on bits a[cnt] then a[cnt+1]. cnt advances by 2, ITER lasts W/2 cycles, and latency is W/2+2 (18 for W=32). Results are bit-identical to the radix-2 build.
  - Undefined: one step per cycle as specified above.

## Structure
- Package otbn_mont_pkg holds:
  - the state enum mont_state_e (IDLE, ITER, FINAL, DONE);
  - the latency localparam, computed from DATA_WIDTH and the macro;
  - the counter width $clog2(DATA_WIDTH).
- Sub-module otbn_mont_step: combinational single radix-2 step with inputs acc, bit, b, q and output acc_next. It is instantiated once, or twice chained under OTBN_MONT_MUL_RADIX4_EN.

## Test plan
All scenarios use W=32, q=3329, R mod q = 1353.
- a=1353, b=17 -> res_o=17, with out_valid_o at exactly cycle 34 (cycle 18 under the macro).
- a=1353, b=1353 -> 1353. a=3328, b=1353 -> 3328. a=0, b=2000 -> 0.
- Hold out_ready_i=0 for 10 cycles after DONE -> res_o and out_valid_o stable, in_ready_o=0, and a second in_valid_i is ignored. Then assert out_ready_i -> the next cycle is IDLE, with in_ready_o=1.
- rst_i asserted at ITER cycle 10 -> the next cycle shows IDLE, out_valid_o=0, busy_o=0, res_o=0. A following a=1353, b=5 -> 5 with normal latency.
- Back-to-back run of 1000 random a, b < q with out_ready_i tied high -> every res_o matches the reference model a·b·R^(-1) mod q, with spacing W+3 cycles between accepts.
- q=8380417 with a=b=q−1 -> res_o equals the model value and is below q (checks the acc < 2q width invariant near the upper modulus range).
